dmi_arbiter: RTL and testbench
==============================

Name: dmi_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the DMI-to-TileLink bridge.
- Port 0 is the JTAG DTM. Port 1 is the secondary debug/test master.
- Grants one DMI transaction at a time and registers the request toward the bridge.
- Routes the bridge response back to the granted requester only, and fabricates a failure response if the bridge never answers.

Parameters:
- TIMEOUT, 1023: cycles to wait in WAIT_RESP before abandoning a transaction; 0 disables the timeout.
- CNT_W, 10: timeout counter width; must satisfy TIMEOUT < 2^CNT_W.

Ports:
- clock  in  1  single clock; all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- io_in_N_req_ready  out  1  (N = 0,1) requester N request accepted.
- io_in_N_req_valid  in  1  requester N request pending.
- io_in_N_req_bits_addr  in  7  DMI register address.
- io_in_N_req_bits_data  in  32  write data.
- io_in_N_req_bits_op  in  2  0 = nop, 1 = read, 2 = write.
- io_in_N_resp_ready  in  1  requester N can take a response.
- io_in_N_resp_valid  out  1  response for requester N.
- io_in_N_resp_bits_data  out  32  read data.
- io_in_N_resp_bits_resp  out  2  0 = ok, 2 = failed.
- io_out_req_ready  in  1  bridge accepts request.
- io_out_req_valid  out  1  request to bridge.
- io_out_req_bits_addr  out  7  registered address.
- io_out_req_bits_data  out  32  registered data.
- io_out_req_bits_op  out  2  registered op.
- io_out_resp_ready  out  1  arbiter accepts bridge response.
- io_out_resp_valid  in  1  bridge response valid.
- io_out_resp_bits_data  in  32  bridge read data.
- io_out_resp_bits_resp  in  2  bridge status.
- io_busy  out  1  high in any state other than IDLE.
- io_owner  out  1  index of the current or last granted requester.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; all valid/ready outputs 0; registered req/resp bits 0.
  - io_owner = 0; rr_last = 1, so port 0 wins first; drain = 0; counter = 0.
- Handshake rule: a transfer fires on valid & ready in the same cycle. A valid, once raised, holds its bits stable until it fires.
- IDLE:
  - io_in_N_req_ready = grant_N.
  - Grant goes to the single valid requester. If both are valid, it goes to the port not equal to rr_last.
  - On fire: capture addr/data/op and owner; rr_last <= owner; go to SEND. The fire decision is registered.
- SEND:
  - io_out_req_valid = 1 from the registered bits, one cycle after the upstream fire.
  - On io_out_req_ready: counter <= 0; go to WAIT_RESP.
  - SEND has no timeout.
- WAIT_RESP:
  - io_out_resp_ready = 1; counter increments each cycle.
  - On io_out_resp_valid: capture data and resp; go to RESP.
  - Else, if TIMEOUT ≠ 0 and counter == TIMEOUT-1: captured data = 0, resp = 2'h2, drain <= 1; go to RESP.
- RESP:
  - io_in_<owner>_resp_valid = 1 with the registered data. The other port's resp_valid stays 0.
  - On the owner's resp_ready: go to IDLE.
  - Minimum latency from upstream req fire to resp_valid is 3 cycles (bridge ready and responding immediately).
- Drain:
  - While drain = 1, io_out_resp_ready = 1 in every state.
  - The next bridge response is discarded and clears drain; it never reaches a requester.
  - While drain = 1, a new transaction may not leave SEND (io_out_req_valid held 0), so a stale response cannot be matched to a new request.
- Simultaneous events:
  - A response arriving on the same cycle the timeout would fire wins: it is captured normally, with no fabricated failure and no drain.
  - A stale (drained) response arriving in the same cycle as a grant: the grant proceeds; the response is discarded.
- Requester deassertion: requester valid drops while the arbiter is non-IDLE are ignored; only IDLE samples requests.
- Op pass-through: op = 0 (nop) is forwarded like any other op.
- io_busy = (state ≠ IDLE) | drain.
- Reset mid-transaction aborts immediately. No response is delivered. The bridge must be reset in the same domain.

Test Plan:
- Single read on port 0 (addr 7'h11, op 1), bridge ready, responds with data 32'hDEADBEEF, resp 0 the next cycle:
  - io_in_0_resp_valid is high with that data 3 cycles after req fire; port 1 sees no resp_valid.
- Both ports valid every cycle for 4 transactions, starting from reset:
  - grant order 0,1,0,1; io_owner matches each response; each response reaches only its owner.
- Port 1 write (addr 7'h10, data 32'h1, op 2), io_out_req_ready held 0 for 5 cycles:
  - io_out_req_valid stays high with stable bits; completes once ready rises; io_busy high throughout.
- TIMEOUT = 8, bridge never responds:
  - owner receives resp 2'h2, data 0, after 8 cycles in WAIT_RESP.
  - A late bridge response is consumed with no requester resp_valid.
  - The next granted request is held in SEND until the drain clears.
- Bridge response on the exact timeout cycle: delivered with the bridge's data, resp 0; drain stays 0.
- Reset asserted in WAIT_RESP:
  - all valids 0 and io_busy 0 immediately, without waiting for a clock edge.
  - After release, the first contended grant goes to port 0.

Source files
------------

// File: rtl/dmi_arbiter.sv
// Two-port arbiter/sequencer in front of the DMI-to-TileLink bridge.
// Grants one DMI transaction at a time and fabricates a failure if the bridge stalls.
//
// state     | meaning
// IDLE      | sample requesters, round-robin grant on contention
// SEND      | present registered request to the bridge
// WAIT_RESP | accept bridge response, run timeout counter
// RESP      | deliver response to the owning requester
module dmi_arbiter #(
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned CNT_W   = 10
) (
  input  logic        clock,
  input  logic        reset,
  output logic        io_in_0_req_ready,
  input  logic        io_in_0_req_valid,
  input  logic [6:0]  io_in_0_req_bits_addr,
  input  logic [31:0] io_in_0_req_bits_data,
  input  logic [1:0]  io_in_0_req_bits_op,
  input  logic        io_in_0_resp_ready,
  output logic        io_in_0_resp_valid,
  output logic [31:0] io_in_0_resp_bits_data,
  output logic [1:0]  io_in_0_resp_bits_resp,
  output logic        io_in_1_req_ready,
  input  logic        io_in_1_req_valid,
  input  logic [6:0]  io_in_1_req_bits_addr,
  input  logic [31:0] io_in_1_req_bits_data,
  input  logic [1:0]  io_in_1_req_bits_op,
  input  logic        io_in_1_resp_ready,
  output logic        io_in_1_resp_valid,
  output logic [31:0] io_in_1_resp_bits_data,
  output logic [1:0]  io_in_1_resp_bits_resp,
  input  logic        io_out_req_ready,
  output logic        io_out_req_valid,
  output logic [6:0]  io_out_req_bits_addr,
  output logic [31:0] io_out_req_bits_data,
  output logic [1:0]  io_out_req_bits_op,
  output logic        io_out_resp_ready,
  input  logic        io_out_resp_valid,
  input  logic [31:0] io_out_resp_bits_data,
  input  logic [1:0]  io_out_resp_bits_resp,
  output logic        io_busy,
  output logic        io_owner
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RESP, RESP} state_t;

  localparam bit               TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TC    = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

  state_t            state_q, state_d;
  logic              owner_q;
  logic              rr_last_q;
  logic              drain_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [6:0]        req_addr_q;
  logic [31:0]       req_data_q;
  logic [1:0]        req_op_q;
  logic [31:0]       resp_data_q;
  logic [1:0]        resp_resp_q;

  logic grant_0, grant_1, grant_any;
  logic owner_resp_ready;
  logic timeout_hit;

  // On contention the port that did not win last time is favoured.
  assign grant_0   = io_in_0_req_valid & (~io_in_1_req_valid | rr_last_q);
  assign grant_1   = io_in_1_req_valid & (~io_in_0_req_valid | ~rr_last_q);
  assign grant_any = grant_0 | grant_1;

  assign owner_resp_ready = owner_q ? io_in_1_resp_ready : io_in_0_resp_ready;
  assign timeout_hit      = TO_EN && (cnt_q == TC);

  always_comb begin
    state_d            = state_q;
    io_in_0_req_ready  = 1'b0;
    io_in_1_req_ready  = 1'b0;
    io_in_0_resp_valid = 1'b0;
    io_in_1_resp_valid = 1'b0;
    io_out_req_valid   = 1'b0;
    io_out_resp_ready  = drain_q;
    case (state_q)
      IDLE: begin
        io_in_0_req_ready = grant_0;
        io_in_1_req_ready = grant_1;
        if (grant_any) state_d = SEND;
      end
      SEND: begin
        // A pending drain blocks the new request so a stale reply cannot pair with it.
        io_out_req_valid = ~drain_q;
        if (~drain_q && io_out_req_ready) state_d = WAIT_RESP;
      end
      WAIT_RESP: begin
        io_out_resp_ready = 1'b1;
        if (io_out_resp_valid || timeout_hit) state_d = RESP;
      end
      RESP: begin
        io_in_0_resp_valid = ~owner_q;
        io_in_1_resp_valid = owner_q;
        if (owner_resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      rr_last_q   <= 1'b1;
      drain_q     <= 1'b0;
      cnt_q       <= '0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      req_op_q    <= '0;
      resp_data_q <= '0;
      resp_resp_q <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == IDLE && grant_any) begin
        owner_q    <= grant_1;
        rr_last_q  <= grant_1;
        req_addr_q <= grant_1 ? io_in_1_req_bits_addr : io_in_0_req_bits_addr;
        req_data_q <= grant_1 ? io_in_1_req_bits_data : io_in_0_req_bits_data;
        req_op_q   <= grant_1 ? io_in_1_req_bits_op   : io_in_0_req_bits_op;
      end

      if (state_q == SEND) begin
        cnt_q <= '0;
      end else if (state_q == WAIT_RESP) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      // A real response on the terminal-count cycle takes priority over the fabricated failure.
      if (state_q == WAIT_RESP) begin
        if (io_out_resp_valid) begin
          resp_data_q <= io_out_resp_bits_data;
          resp_resp_q <= io_out_resp_bits_resp;
        end else if (timeout_hit) begin
          resp_data_q <= '0;
          resp_resp_q <= 2'h2;
          drain_q     <= 1'b1;
        end
      end else if (drain_q && io_out_resp_valid) begin
        drain_q <= 1'b0;
      end
    end
  end

  assign io_out_req_bits_addr   = req_addr_q;
  assign io_out_req_bits_data   = req_data_q;
  assign io_out_req_bits_op     = req_op_q;
  assign io_in_0_resp_bits_data = resp_data_q;
  assign io_in_0_resp_bits_resp = resp_resp_q;
  assign io_in_1_resp_bits_data = resp_data_q;
  assign io_in_1_resp_bits_resp = resp_resp_q;
  assign io_busy                = (state_q != IDLE) | drain_q;
  assign io_owner               = owner_q;

endmodule

// File: tb/tb_dmi_arbiter.sv
// Directed, table-driven bench for dmi_arbiter with a short timeout.
// Table covers full transactions; hand sequences cover timeout, drain and reset.
module tb_dmi_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        in0_req_ready, in0_req_valid, in0_resp_ready, in0_resp_valid;
  logic [6:0]  in0_addr;
  logic [31:0] in0_data, in0_resp_data;
  logic [1:0]  in0_op, in0_resp_resp;
  logic        in1_req_ready, in1_req_valid, in1_resp_ready, in1_resp_valid;
  logic [6:0]  in1_addr;
  logic [31:0] in1_data, in1_resp_data;
  logic [1:0]  in1_op, in1_resp_resp;
  logic        out_req_ready, out_req_valid, out_resp_ready, out_resp_valid;
  logic [6:0]  out_addr;
  logic [31:0] out_data, out_resp_data;
  logic [1:0]  out_op, out_resp_resp;
  logic        busy, owner;

  int n_checks = 0;
  int n_errors = 0;

  dmi_arbiter #(.TIMEOUT(8), .CNT_W(10)) dut (
    .clock(clock), .reset(reset),
    .io_in_0_req_ready(in0_req_ready), .io_in_0_req_valid(in0_req_valid),
    .io_in_0_req_bits_addr(in0_addr), .io_in_0_req_bits_data(in0_data),
    .io_in_0_req_bits_op(in0_op), .io_in_0_resp_ready(in0_resp_ready),
    .io_in_0_resp_valid(in0_resp_valid), .io_in_0_resp_bits_data(in0_resp_data),
    .io_in_0_resp_bits_resp(in0_resp_resp),
    .io_in_1_req_ready(in1_req_ready), .io_in_1_req_valid(in1_req_valid),
    .io_in_1_req_bits_addr(in1_addr), .io_in_1_req_bits_data(in1_data),
    .io_in_1_req_bits_op(in1_op), .io_in_1_resp_ready(in1_resp_ready),
    .io_in_1_resp_valid(in1_resp_valid), .io_in_1_resp_bits_data(in1_resp_data),
    .io_in_1_resp_bits_resp(in1_resp_resp),
    .io_out_req_ready(out_req_ready), .io_out_req_valid(out_req_valid),
    .io_out_req_bits_addr(out_addr), .io_out_req_bits_data(out_data),
    .io_out_req_bits_op(out_op), .io_out_resp_ready(out_resp_ready),
    .io_out_resp_valid(out_resp_valid), .io_out_resp_bits_data(out_resp_data),
    .io_out_resp_bits_resp(out_resp_resp),
    .io_busy(busy), .io_owner(owner)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        v0;
    logic        v1;
    logic [1:0]  op;
    int          stall;
    logic [31:0] bdata;
    logic [1:0]  bresp;
    logic        exp_own;
  } vec_t;

  vec_t vecs[8];

  localparam logic [6:0]  P0_ADDR = 7'h11;
  localparam logic [31:0] P0_DATA = 32'hA5A5_0000;
  localparam logic [6:0]  P1_ADDR = 7'h10;
  localparam logic [31:0] P1_DATA = 32'h0000_0001;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run_txn(input vec_t v);
    logic [6:0]  ea;
    logic [31:0] ed;
    ea = v.exp_own ? P1_ADDR : P0_ADDR;
    ed = v.exp_own ? P1_DATA : P0_DATA;
    in0_req_valid = v.v0; in0_addr = P0_ADDR; in0_data = P0_DATA; in0_op = v.op;
    in1_req_valid = v.v1; in1_addr = P1_ADDR; in1_data = P1_DATA; in1_op = v.op;
    #1;
    chk("grant0", 32'(in0_req_ready), 32'(v.exp_own == 1'b0));
    chk("grant1", 32'(in1_req_ready), 32'(v.exp_own == 1'b1));
    step();
    for (int s = 0; s < v.stall; s++) begin
      chk("stall_valid", 32'(out_req_valid), 32'd1);
      chk("stall_addr", 32'(out_addr), 32'(ea));
      chk("stall_busy", 32'(busy), 32'd1);
      step();
    end
    chk("req_valid", 32'(out_req_valid), 32'd1);
    chk("req_addr", 32'(out_addr), 32'(ea));
    chk("req_data", out_data, ed);
    chk("req_op", 32'(out_op), 32'(v.op));
    chk("busy_send", 32'(busy), 32'd1);
    chk("no_ready_nonidle", 32'({in0_req_ready, in1_req_ready}), 32'd0);
    out_req_ready = 1'b1;
    step();
    out_req_ready = 1'b0;
    chk("resp_ready_wait", 32'(out_resp_ready), 32'd1);
    out_resp_valid = 1'b1; out_resp_data = v.bdata; out_resp_resp = v.bresp;
    step();
    out_resp_valid = 1'b0;
    chk("resp_valid0", 32'(in0_resp_valid), 32'(v.exp_own == 1'b0));
    chk("resp_valid1", 32'(in1_resp_valid), 32'(v.exp_own == 1'b1));
    chk("resp_data", v.exp_own ? in1_resp_data : in0_resp_data, v.bdata);
    chk("resp_resp", 32'(v.exp_own ? in1_resp_resp : in0_resp_resp), 32'(v.bresp));
    chk("owner", 32'(owner), 32'(v.exp_own));
    if (v.exp_own) in1_resp_ready = 1'b1; else in0_resp_ready = 1'b1;
    step();
    in0_resp_ready = 1'b0; in1_resp_ready = 1'b0;
    in0_req_valid = 1'b0; in1_req_valid = 1'b0;
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 2'd1, 0, 32'h1111_0000, 2'd0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 2'd2, 0, 32'h2222_0000, 2'd0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 2'd1, 0, 32'h3333_0000, 2'd0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 2'd0, 0, 32'h4444_0000, 2'd0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 2'd1, 0, 32'hDEAD_BEEF, 2'd0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 2'd2, 5, 32'h0000_0000, 2'd0, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 2'd1, 0, 32'h1234_5678, 2'd2, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 2'd1, 0, 32'h8765_4321, 2'd0, 1'b0};

    reset = 1'b0;
    in0_req_valid = 0; in0_addr = 0; in0_data = 0; in0_op = 0; in0_resp_ready = 0;
    in1_req_valid = 0; in1_addr = 0; in1_data = 0; in1_op = 0; in1_resp_ready = 0;
    out_req_ready = 0; out_resp_valid = 0; out_resp_data = 0; out_resp_resp = 0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_valid", 32'(out_req_valid), 32'd0);
    chk("rst_resp_ready", 32'(out_resp_ready), 32'd0);
    chk("rst_resp_valids", 32'({in0_resp_valid, in1_resp_valid}), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_req_bits", 32'(out_addr), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    step();

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Timeout: bridge silent, failure fabricated, then drain holds the next request.
    in0_req_valid = 1'b1; in0_addr = P0_ADDR; in0_data = P0_DATA; in0_op = 2'd1;
    step();
    in0_req_valid = 1'b0;
    out_req_ready = 1'b1;
    step();
    out_req_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("to_waiting", 32'(in0_resp_valid), 32'd0);
    end
    step();
    chk("to_resp_valid", 32'(in0_resp_valid), 32'd1);
    chk("to_resp_other", 32'(in1_resp_valid), 32'd0);
    chk("to_resp_data", in0_resp_data, 32'd0);
    chk("to_resp_resp", 32'(in0_resp_resp), 32'd2);
    in0_resp_ready = 1'b1;
    step();
    in0_resp_ready = 1'b0;
    chk("drain_busy", 32'(busy), 32'd1);
    chk("drain_resp_ready", 32'(out_resp_ready), 32'd1);
    in1_req_valid = 1'b1; in1_addr = P1_ADDR; in1_data = P1_DATA; in1_op = 2'd2;
    #1;
    chk("drain_grant1", 32'(in1_req_ready), 32'd1);
    step();
    in1_req_valid = 1'b0;
    out_req_ready = 1'b1;
    chk("drain_hold_a", 32'(out_req_valid), 32'd0);
    step();
    chk("drain_hold_b", 32'(out_req_valid), 32'd0);
    out_resp_valid = 1'b1; out_resp_data = 32'hBAD0_0BAD; out_resp_resp = 2'd0;
    step();
    out_resp_valid = 1'b0;
    chk("stale_dropped", 32'({in0_resp_valid, in1_resp_valid}), 32'd0);
    chk("drain_released", 32'(out_req_valid), 32'd1);
    step();
    out_req_ready = 1'b0;
    out_resp_valid = 1'b1; out_resp_data = 32'h0000_600D; out_resp_resp = 2'd0;
    step();
    out_resp_valid = 1'b0;
    chk("post_drain_valid1", 32'(in1_resp_valid), 32'd1);
    chk("post_drain_valid0", 32'(in0_resp_valid), 32'd0);
    chk("post_drain_data", in1_resp_data, 32'h0000_600D);
    in1_resp_ready = 1'b1;
    step();
    in1_resp_ready = 1'b0;
    chk("post_drain_idle", 32'(busy), 32'd0);

    // Response lands on the terminal-count cycle and must win.
    in0_req_valid = 1'b1; in0_op = 2'd1;
    step();
    in0_req_valid = 1'b0;
    out_req_ready = 1'b1;
    step();
    out_req_ready = 1'b0;
    for (int i = 0; i < 7; i++) step();
    out_resp_valid = 1'b1; out_resp_data = 32'hCAFE_F00D; out_resp_resp = 2'd0;
    step();
    out_resp_valid = 1'b0;
    chk("tc_resp_valid", 32'(in0_resp_valid), 32'd1);
    chk("tc_resp_data", in0_resp_data, 32'hCAFE_F00D);
    chk("tc_resp_resp", 32'(in0_resp_resp), 32'd0);
    in0_resp_ready = 1'b1;
    step();
    in0_resp_ready = 1'b0;
    chk("tc_no_drain", 32'(busy), 32'd0);
    chk("tc_resp_ready", 32'(out_resp_ready), 32'd0);

    // Reset while in WAIT_RESP after a port-0 grant.
    in0_req_valid = 1'b1;
    step();
    in0_req_valid = 1'b0;
    out_req_ready = 1'b1;
    step();
    out_req_ready = 1'b0;
    step();
    chk("pre_rst_wait", 32'(out_resp_ready), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_resp_ready", 32'(out_resp_ready), 32'd0);
    chk("arst_valids", 32'({out_req_valid, in0_resp_valid, in1_resp_valid}), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    in0_req_valid = 1'b1; in1_req_valid = 1'b1;
    #1;
    chk("arst_grant0", 32'(in0_req_ready), 32'd1);
    chk("arst_grant1", 32'(in1_req_ready), 32'd0);
    step();
    in0_req_valid = 1'b0; in1_req_valid = 1'b0;
    chk("arst_owner", 32'(owner), 32'd0);
    chk("arst_send", 32'(out_req_valid), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
